multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the RV32I core. Sequences fetch/decode/execute/memory/writeback and
//  drives every datapath select: PC/IR enables, immgen imm_sel, ALU operand muxes, regfile write,
//  shared instruction/data memory port (one requester, req/ready handshake). Sits beside the
//  datapath; consumes IR opcode/funct3 and branch-compare result.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles for mem_ready per access before TRAP (1..255)
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst          in   1      synchronous, active-high reset
//  opcode       in   7      IR[6:0]
//  funct3       in   3      IR[14:12]
//  br_taken     in   1      branch comparator result, valid in EXEC
//  mem_ready    in   1      memory completes access this cycle (sampled only while mem_req=1)
//  mem_req      out  1      memory access request, held until mem_ready
//  mem_we       out  1      store strobe (qualified by mem_req)
//  mem_addr_sel out  1      0=PC (fetch), 1=ALU result (load/store)
//  ir_we        out  1      latch instruction into IR
//  pc_we        out  1      update PC
//  pc_src       out  2      0=PC+4, 1=ALU target, 2=ALU target & ~1 (JALR)
//  imm_sel      out  1      immgen enable; 0 forces imm=0
//  alu_a_sel    out  1      0=rs1, 1=PC
//  alu_b_sel    out  1      0=rs2, 1=imm
//  alu_op       out  2      0=ADD, 1=funct-decoded, 2=branch compare, 3=pass B (LUI)
//  reg_we       out  1      regfile write enable
//  wb_sel       out  2      0=ALU, 1=mem rdata, 2=PC+4
//  trap         out  1      sticky: illegal opcode or memory timeout
//  state_dbg    out  3      current state encoding
//  instret      out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - States: RST(0) FETCH(1) DECODE(2) EXEC(3) MEM(4) WB(5) TRAP(7). Outputs decoded from state
//    (+opcode/br_taken/mem_ready where noted).
//  - rst: next edge -> RST; instret=0, trap=0, wait counter=0. RST drives all outputs 0;
//    RST -> FETCH unconditionally. Reset mid-access abandons it (mem_req low in RST).
//  - FETCH: mem_req=1, mem_addr_sel=0. mem_ready=1 -> ir_we=1 same cycle, -> DECODE.
//    Else wait counter++; counter reaching MEM_TIMEOUT -> TRAP. Counter clears on each new access.
//  - DECODE: imm_sel=1 except R-type (0110011). Legal opcodes: 0110011,0010011,0000011,0100011,
//    1100011,1101111,1100111,0110111,0010111; other -> TRAP. Legal -> EXEC.
//  - EXEC: R/I-ALU: alu_op=1, b_sel per type -> WB. LUI: alu_op=3 -> WB. AUIPC: a_sel=1,b_sel=1,ADD -> WB.
//    Load/store: ADD rs1+imm -> MEM. JAL: a_sel=1,b_sel=1 -> WB. JALR: a_sel=0,b_sel=1 -> WB.
//    Branch: alu_op=2; pc_we=1, pc_src=br_taken?1:0 (target via PC+imm) -> FETCH; retires here.
//  - MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for stores. Same timeout rule as FETCH.
//    On mem_ready: store -> pc_we=1,pc_src=0, retire, -> FETCH; load -> WB.
//  - WB: reg_we=1, pc_we=1. wb_sel=1 load, 2 JAL/JALR (pc_src=1/2), else 0 with pc_src=0. -> FETCH.
//  - Latency (zero-wait mem): branch 3, ALU/LUI/AUIPC/JAL/JALR/store 4, load 5 cycles.
//  - instret += 1 exactly on cycles with pc_we=1; wraps all-ones -> 0.
//  - TRAP: trap=1, all other outputs 0, no exit except rst.
//  - mem_ready when mem_req=0 is ignored; opcode must be stable from DECODE to retirement.
// TESTING
//  1 rst 2 cycles, IR=ADDI(0x06400093), mem_ready=1 -> RST,FETCH,DECODE,EXEC,WB; reg_we=1 in WB
//    only; imm_sel=1; instret=1 after 4 cycles.
//  2 BEQ, br_taken=1 -> pc_we=1,pc_src=1 in EXEC, no reg_we; br_taken=0 -> pc_src=0; 3 cycles each.
//  3 LW with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, mem_addr_sel=1, then WB wb_sel=1.
//  4 Fetch with mem_ready never high, MEM_TIMEOUT=15 -> TRAP after 15 wait cycles, trap=1 stays.
//  5 opcode=7'b1111111 in DECODE -> TRAP next cycle; rst -> RST, trap=0, instret=0.
//  6 CNT_W=4, 16 ADD retirements -> instret wraps 15 -> 0; rst asserted mid-MEM -> mem_req=0 next cycle.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port between the multicycle control FSM
// (single requester) and the memory: req/ready handshake plus address/store selects.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for an RV32I core: sequences fetch/decode/execute/memory/writeback,
// drives every datapath select, counts retired instructions and traps on illegal ops or memory timeouts.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  mem,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               br_taken,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               imm_sel,
  output logic               alu_a_sel,
  output logic               alu_b_sel,
  output logic [1:0]         alu_op,
  output logic               reg_we,
  output logic [1:0]         wb_sel,
  output logic               trap,
  output logic [2:0]         state_dbg,
  output logic [CNT_W-1:0]   instret
);

  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Last wait cycle allowed before an access is declared dead.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] wait_cnt;
  logic       wait_hit;
  logic       opcode_legal;
  logic       is_store;
  logic       is_mem_op;
  logic       req;
  logic       we;
  logic       addr_sel;

  // funct3 refinement happens in the datapath's ALU decoder; the FSM only needs the opcode.
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  assign is_store  = (opcode == OP_STORE);
  assign is_mem_op = (opcode == OP_LOAD) || is_store;
  assign wait_hit  = (wait_cnt == WAIT_LAST);

  always_comb begin
    opcode_legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_legal = 1'b1;
      default:                           opcode_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:    state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready_i())   state_nxt = S_DECODE;
        else if (wait_hit)   state_nxt = S_TRAP;
      end
      S_DECODE: state_nxt = opcode_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_mem_op)                  state_nxt = S_MEM;
        else if (opcode == OP_BRANCH)   state_nxt = S_FETCH;
        else                            state_nxt = S_WB;
      end
      S_MEM: begin
        if (mem_ready_i())   state_nxt = is_store ? S_FETCH : S_WB;
        else if (wait_hit)   state_nxt = S_TRAP;
      end
      S_WB:     state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      // The unused encoding is treated as corruption and parked like a trap.
      default:  state_nxt = S_TRAP;
    endcase
  end

  function automatic logic mem_ready_i();
    return mem.mem_ready;
  endfunction

  // NOTE: every output gets a default before the case, so no path through the block leaves a latch.
  always_comb begin
    req       = 1'b0;
    we        = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    imm_sel   = 1'b0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = 2'd0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    case (state)
      S_FETCH: begin
        req   = 1'b1;
        ir_we = mem.mem_ready;
      end
      S_DECODE: imm_sel = (opcode != OP_R);
      S_EXEC: begin
        imm_sel = (opcode != OP_R);
        case (opcode)
          OP_R:     alu_op = 2'd1;
          OP_I: begin
            alu_op    = 2'd1;
            alu_b_sel = 1'b1;
          end
          OP_LUI: begin
            alu_op    = 2'd3;
            alu_b_sel = 1'b1;
          end
          OP_AUIPC, OP_JAL: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
          end
          OP_LOAD, OP_STORE, OP_JALR: alu_b_sel = 1'b1;
          OP_BRANCH: begin
            alu_op = 2'd2;
            pc_we  = 1'b1;
            pc_src = br_taken ? 2'd1 : 2'd0;
          end
          default: alu_op = 2'd0;
        endcase
      end
      S_MEM: begin
        imm_sel  = 1'b1;
        req      = 1'b1;
        addr_sel = 1'b1;
        we       = is_store;
        // A store is complete once memory accepts it; nothing left to write back.
        pc_we    = is_store && mem.mem_ready;
      end
      S_WB: begin
        imm_sel = (opcode != OP_R);
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        case (opcode)
          OP_LOAD: wb_sel = 2'd1;
          OP_JAL: begin
            wb_sel = 2'd2;
            pc_src = 2'd1;
          end
          OP_JALR: begin
            wb_sel = 2'd2;
            pc_src = 2'd2;
          end
          default: wb_sel = 2'd0;
        endcase
      end
      default: req = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RST;
      wait_cnt <= 8'd0;
      instret  <= '0;
    end else begin
      state <= state_nxt;
      // Counts consecutive unanswered request cycles; any completion or non-memory state clears it.
      if ((state == S_FETCH || state == S_MEM) && !mem.mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;
      if (pc_we)
        instret <= instret + CNT_W'(1);
    end
  end

  assign mem.mem_req      = req;
  assign mem.mem_we       = we;
  assign mem.mem_addr_sel = addr_sel;
  assign trap             = (state == S_TRAP);
  assign state_dbg        = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: a memory/IR responder issues instructions,
// a monitor checks each retirement against a per-opcode reference model, then directed trap/reset cases.
module tb_multicycle_ctrl;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             br_taken;
  logic             ir_we, pc_we, imm_sel, alu_a_sel, alu_b_sel, reg_we, trap;
  logic [1:0]       pc_src, alu_op, wb_sel;
  logic [2:0]       state_dbg;
  logic [CNT_W-1:0] instret;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mem(mif), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .imm_sel(imm_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .trap(trap),
    .state_dbg(state_dbg), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    bit         br;
    int         fw;
    int         mw;
  } instr_t;

  typedef struct {
    logic [6:0] op;
    int alu_op, a_sel, b_sel, pc_src, reg_we, wb_sel, mem_we, lat;
  } exp_t;

  instr_t     prog[$];
  exp_t       sb[$];
  logic [6:0] legal_ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what one instruction must look like at its retirement cycle.
  function automatic exp_t model(input instr_t ins);
    exp_t e;
    e = '{op: ins.op, alu_op: 0, a_sel: 0, b_sel: 0, pc_src: 0, reg_we: 0, wb_sel: 0, mem_we: 0, lat: 4};
    case (ins.op)
      OP_R:      begin e.alu_op = 1; e.reg_we = 1; end
      OP_I:      begin e.alu_op = 1; e.b_sel = 1; e.reg_we = 1; end
      OP_LUI:    begin e.alu_op = 3; e.b_sel = 1; e.reg_we = 1; end
      OP_AUIPC:  begin e.a_sel = 1; e.b_sel = 1; e.reg_we = 1; end
      OP_LOAD:   begin e.b_sel = 1; e.reg_we = 1; e.wb_sel = 1; e.lat = 5 + ins.mw; end
      OP_STORE:  begin e.b_sel = 1; e.mem_we = 1; e.lat = 4 + ins.mw; end
      OP_JAL:    begin e.a_sel = 1; e.b_sel = 1; e.reg_we = 1; e.wb_sel = 2; e.pc_src = 1; end
      OP_JALR:   begin e.b_sel = 1; e.reg_we = 1; e.wb_sel = 2; e.pc_src = 2; end
      OP_BRANCH: begin e.alu_op = 2; e.pc_src = ins.br ? 1 : 0; e.lat = 3; end
      default:   e.lat = 0;
    endcase
    e.lat += ins.fw;
    return e;
  endfunction

  function automatic instr_t mk(input logic [6:0] op, input bit br, input int fw, input int mw);
    instr_t i;
    i = '{op: op, f3: 3'd0, br: br, fw: fw, mw: mw};
    return i;
  endfunction

  // Memory / IR responder state
  bit in_access = 1'b0;
  int wait_left = 0;
  int cur_mw    = 0;

  task automatic issue();
    instr_t ins;
    ins      = prog.pop_front();
    opcode   = ins.op;
    funct3   = ins.f3;
    br_taken = ins.br;
    cur_mw   = ins.mw;
    sb.push_back(model(ins));
  endtask

  task automatic mem_step();
    if (mif.mem_req) begin
      if (!in_access) begin
        in_access = 1'b1;
        if (mif.mem_addr_sel) wait_left = cur_mw;
        else                  wait_left = (prog.size() > 0) ? prog[0].fw : 1000;
      end
      if (wait_left > 0) begin
        mif.mem_ready = 1'b0;
        wait_left--;
      end else begin
        mif.mem_ready = 1'b1;
        in_access     = 1'b0;
        if (!mif.mem_addr_sel) issue();
      end
    end else begin
      in_access     = 1'b0;
      mif.mem_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Monitor: samples just after the responder drives, compares on every retirement.
  initial begin
    int lat;
    int exp_ir;
    int ex_op, ex_a, ex_b;
    exp_t e;
    lat = 0; exp_ir = 0; ex_op = 0; ex_a = 0; ex_b = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        lat    = -1;
        exp_ir = 0;
      end else begin
        lat++;
        if (state_dbg == 3'd3) begin
          ex_op = alu_op; ex_a = alu_a_sel; ex_b = alu_b_sel;
        end
        if (pc_we) begin
          if (sb.size() == 0) begin
            check("unexpected_retire", 1, 0);
          end else begin
            e = sb.pop_front();
            check($sformatf("alu_op op=%b", e.op), ex_op, e.alu_op);
            check($sformatf("alu_a_sel op=%b", e.op), ex_a, e.a_sel);
            check($sformatf("alu_b_sel op=%b", e.op), ex_b, e.b_sel);
            check($sformatf("pc_src op=%b", e.op), pc_src, e.pc_src);
            check($sformatf("reg_we op=%b", e.op), reg_we, e.reg_we);
            check($sformatf("wb_sel op=%b", e.op), wb_sel, e.wb_sel);
            check($sformatf("mem_we op=%b", e.op), mif.mem_we, e.mem_we);
            check($sformatf("latency op=%b", e.op), lat, e.lat);
          end
          check("instret", instret, exp_ir);
          exp_ir = (exp_ir + 1) % (1 << CNT_W);
          lat = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int cyc;
    int fetch_cycles;
    rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; br_taken = 1'b0; mif.mem_ready = 1'b0;

    prog.push_back(mk(OP_I, 0, 0, 0));
    prog.push_back(mk(OP_BRANCH, 1, 0, 0));
    prog.push_back(mk(OP_BRANCH, 0, 0, 0));
    prog.push_back(mk(OP_LOAD, 0, 0, 3));
    prog.push_back(mk(OP_STORE, 0, 1, 2));
    prog.push_back(mk(OP_JAL, 0, 0, 0));
    prog.push_back(mk(OP_JALR, 0, 2, 0));
    prog.push_back(mk(OP_LUI, 0, 0, 0));
    prog.push_back(mk(OP_AUIPC, 0, 0, 0));
    prog.push_back(mk(OP_R, 0, 0, 0));
    for (int i = 0; i < 16; i++) prog.push_back(mk(OP_R, 0, 0, 0));
    for (int i = 0; i < 147; i++) begin
      instr_t r;
      r    = mk(legal_ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3));
      r.f3 = 3'($urandom);
      prog.push_back(r);
    end

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", state_dbg, 0);
    check("reset_outputs_zero", {mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_we, pc_we, pc_src,
          imm_sel, alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel}, 0);
    check("reset_trap", trap, 0);
    check("reset_instret", instret, 0);
    rst = 1'b0;

    // Randomized program through the scoreboard
    cyc = 0;
    while ((prog.size() > 0 || sb.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      mem_step();
      cyc++;
    end
    check("program_drained", prog.size() + sb.size(), 0);

    // Reset asserted in the middle of a load's memory access
    @(negedge clk); rst = 1'b1; mif.mem_ready = 1'b0; in_access = 1'b0; sb.delete();
    @(negedge clk); rst = 1'b0;
    #1 check("rst_release_state", state_dbg, 0);
    check("rst_clears_instret", instret, 0);
    @(negedge clk); mif.mem_ready = 1'b1; opcode = OP_LOAD; br_taken = 1'b0;
    #1 check("fetch_ir_we", ir_we, 1);
    check("fetch_addr_sel", mif.mem_addr_sel, 0);
    @(negedge clk); mif.mem_ready = 1'b0;
    #1 check("load_decode_imm_sel", imm_sel, 1);
    @(negedge clk);
    #1 check("load_exec_state", state_dbg, 3);
    @(negedge clk);
    #1 check("load_mem_addr_sel", mif.mem_addr_sel, 1);
    @(negedge clk); rst = 1'b1;
    #1 check("mem_req_held", mif.mem_req, 1);
    @(negedge clk); rst = 1'b0;
    #1 check("mem_req_dropped_by_rst", mif.mem_req, 0);
    check("rst_mid_mem_state", state_dbg, 0);

    // Fetch that is never answered must time out
    fetch_cycles = 0;
    @(negedge clk);
    #1;
    while (state_dbg == 3'd1 && fetch_cycles < 40) begin
      fetch_cycles++;
      @(negedge clk);
      #1;
    end
    check("timeout_fetch_cycles", fetch_cycles, MEM_TIMEOUT);
    check("timeout_trap", trap, 1);
    check("timeout_state", state_dbg, 7);
    check("trap_outputs_zero", {mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_we, pc_we, pc_src,
          imm_sel, alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mif.mem_ready = 1'($urandom_range(0, 1));
    end
    #1 check("trap_sticky", trap, 1);

    // Reset leaves trap; illegal opcode traps from DECODE
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 check("rst_clears_trap", trap, 0);
    @(negedge clk); mif.mem_ready = 1'b1; opcode = 7'b1111111;
    #1 check("illegal_fetch_state", state_dbg, 1);
    @(negedge clk); mif.mem_ready = 1'b0;
    #1 check("illegal_decode_state", state_dbg, 2);
    @(negedge clk);
    #1 check("illegal_trap", trap, 1);
    check("illegal_trap_state", state_dbg, 7);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 check("final_rst_trap", trap, 0);
    check("final_rst_instret", instret, 0);
    check("final_rst_state", state_dbg, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
